countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Down-counting BCD timer in M:SS format, the reverse of the up-counting Timer in the music player.
- It is loaded with the remaining track time and decrements once per second while enabled.
- It flags expiry so the player control FSM can stop playback or advance to the next track.
- The digit outputs use the same BCD format as Timer, so both blocks can share the display path.

Parameters:
- TICKS_PER_SECOND, 50000000: number of clk cycles per one-second decrement; must be ≥1. Benches use 4.
- PRESCALE_WIDTH, 26: width of the prescaler counter; must satisfy 2^PRESCALE_WIDTH ≥ TICKS_PER_SECOND.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- count  input  1  enable; 1 = run, 0 = pause/hold.
- load  input  1  load the preset digits on this edge.
- minutes0_in  input  4  preset minutes digit, BCD.
- seconds1_in  input  4  preset tens-of-seconds digit, BCD.
- seconds0_in  input  4  preset units-of-seconds digit, BCD.
- minutes0  output  4  current minutes digit.
- seconds1  output  4  current tens-of-seconds digit.
- seconds0  output  4  current units-of-seconds digit.
- done  output  1  one-cycle pulse on reaching 0:00 by counting.
- expired  output  1  level; high while the value is 0:00.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, sampled on the rising edge of clk. All outputs are registered.
- Reset (highest priority):
  - minutes0 = seconds1 = seconds0 = 0; prescaler = 0.
  - done = 0; expired = 1, since 0:00 counts as expired.
- Load (second priority; wins over count and over a simultaneous tick):
  - Digits take the preset values, clamped per digit: seconds0_in > 9 → 9; seconds1_in > 5 → 5; minutes0_in > 9 → 9.
  - Prescaler cleared to 0; done = 0.
  - expired = 1 if the loaded value is 0:00, else 0. Loading 0:00 never pulses done.
- Run: count = 1, expired = 0, no load.
  - Prescaler increments each cycle.
  - When the prescaler equals TICKS_PER_SECOND − 1, it wraps to 0 and a tick decrements the value on that same edge.
  - Latency: the first decrement lands on the TICKS_PER_SECOND-th rising edge with count = 1 after load.
- Decrement (BCD borrow chain):
  - seconds0 > 0: seconds0 − 1.
  - Else seconds0 = 9, and if seconds1 > 0: seconds1 − 1.
  - Else seconds1 = 5 and minutes0 − 1.
  - The chain is never entered from 0:00, so there is no underflow and no wrap to 9:59.
- Expiry:
  - If a tick yields 0:00, expired = 1 and done = 1 on the same edge. done clears on the next edge.
  - While expired: digits hold at 0:00, prescaler holds at 0, count is ignored. Only load or reset leave this state.
- Pause: count = 0 holds digits and prescaler (no prescaler reset). Resuming continues the partial second.
- Reset mid-operation: asserting reset during run or pause overrides everything on that edge. Digits go to 0:00 and expired = 1; no done pulse is produced.
- States are implicit in expired/count:
  - IDLE_EXPIRED (expired = 1): on load with a nonzero value → RUN/PAUSE.
  - RUN (count = 1): a tick to 0:00 → IDLE_EXPIRED.
  - PAUSE (count = 0): count = 1 → RUN.
- done is never high for two consecutive cycles.

Test Plan (TICKS_PER_SECOND = 4):
1. reset = 1 for 2 edges → 0:00, expired = 1, done = 0. Then count = 1 for 20 edges → outputs unchanged, done stays 0.
2. load 2:00, count = 1 → still 2:00 after 3 edges; 1:59 after edge 4 (borrow across both digits); 1:58 after edge 8.
3. load 0:02, count = 1 → 0:01 at edge 4; 0:00 at edge 8 with done = 1 for exactly one cycle and expired = 1. 40 more edges → still 0:00, done = 0.
4. load 0:05, count = 1 for 6 edges → 0:04 with prescaler = 2. count = 0 for 20 edges → holds 0:04. count = 1 for 2 edges → 0:03.
5. load with minutes0_in = 12, seconds1_in = 7, seconds0_in = 11 → 9:59, expired = 0. load 0:00 → expired = 1 with no done pulse.
6. Running 0:10: assert load = 3:30 on the tick edge → 3:30 (load wins). Later assert reset mid-second → 0:00, expired = 1, done = 0.

Source files
------------

// File: rtl/countdown_timer.sv
// Down-counting M:SS BCD timer for the music player. Loaded with the remaining
// track time, it decrements once per second and flags when it reaches 0:00.
module countdown_timer #(
  parameter int TICKS_PER_SECOND = 50000000,
  parameter int PRESCALE_WIDTH   = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       count,
  input  logic       load,
  input  logic [3:0] minutes0_in,
  input  logic [3:0] seconds1_in,
  input  logic [3:0] seconds0_in,
  output logic [3:0] minutes0,
  output logic [3:0] seconds1,
  output logic [3:0] seconds0,
  output logic       done,
  output logic       expired
);

  typedef struct packed {
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam logic [PRESCALE_WIDTH-1:0] LAST_TICK = PRESCALE_WIDTH'(TICKS_PER_SECOND - 1);

  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      tick;
  bcd_time_t                 cur, dec, preset;
  logic                      dec_zero, preset_zero;

  assign cur  = '{m0: minutes0, s1: seconds1, s0: seconds0};
  assign tick = (prescale == LAST_TICK);

  // Out-of-range preset digits saturate rather than wrap.
  always_comb begin
    preset.m0   = (minutes0_in > 4'd9) ? 4'd9 : minutes0_in;
    preset.s1   = (seconds1_in > 4'd5) ? 4'd5 : seconds1_in;
    preset.s0   = (seconds0_in > 4'd9) ? 4'd9 : seconds0_in;
    preset_zero = (preset == '0);
  end

  // BCD borrow chain; never evaluated from 0:00 because expiry gates counting.
  always_comb begin
    dec = cur;
    if (cur.s0 != 4'd0) begin
      dec.s0 = cur.s0 - 4'd1;
    end else begin
      dec.s0 = 4'd9;
      if (cur.s1 != 4'd0) begin
        dec.s1 = cur.s1 - 4'd1;
      end else begin
        dec.s1 = 4'd5;
        dec.m0 = cur.m0 - 4'd1;
      end
    end
    dec_zero = (cur.m0 == 4'd0) && (cur.s1 == 4'd0) && (cur.s0 == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      minutes0 <= 4'd0;
      seconds1 <= 4'd0;
      seconds0 <= 4'd0;
      prescale <= '0;
      done     <= 1'b0;
      expired  <= 1'b1;
    end else if (load) begin
      minutes0 <= preset.m0;
      seconds1 <= preset.s1;
      seconds0 <= preset.s0;
      prescale <= '0;
      done     <= 1'b0;
      expired  <= preset_zero;
    end else begin
      done <= 1'b0;
      // Pause holds the partial second so a resume picks up where it stopped.
      if (count && !expired) begin
        if (tick) begin
          prescale <= '0;
          minutes0 <= dec.m0;
          seconds1 <= dec.s1;
          seconds0 <= dec.s0;
          if (dec_zero) begin
            expired <= 1'b1;
            done    <= 1'b1;
          end
        end else begin
          prescale <= prescale + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a seconds-based reference model checked every
// cycle, plus directed literal expectations from the test plan.
module tb_countdown_timer;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset, count, load;
  logic [3:0] minutes0_in, seconds1_in, seconds0_in;
  logic [3:0] minutes0, seconds1, seconds0;
  logic       done, expired;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.TICKS_PER_SECOND(T), .PRESCALE_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .count(count), .load(load),
    .minutes0_in(minutes0_in), .seconds1_in(seconds1_in), .seconds0_in(seconds0_in),
    .minutes0(minutes0), .seconds1(seconds1), .seconds0(seconds0),
    .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as total seconds, prescaler as an integer.
  int m_tot = 0;
  int m_pre = 0;
  bit m_done = 1'b0;
  bit chk_en = 1'b0;

  function automatic int clamp(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_tot  <= 0;
      m_pre  <= 0;
      m_done <= 1'b0;
      chk_en <= 1'b1;
    end else if (load) begin
      m_tot  <= clamp(int'(minutes0_in), 9) * 60 + clamp(int'(seconds1_in), 5) * 10
              + clamp(int'(seconds0_in), 9);
      m_pre  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (count && m_tot != 0) begin
        if (m_pre == T - 1) begin
          m_pre  <= 0;
          m_tot  <= m_tot - 1;
          m_done <= (m_tot == 1);
        end else begin
          m_pre <= m_pre + 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_m0", int'(minutes0), m_tot / 60);
      check("model_s1", int'(seconds1), (m_tot % 60) / 10);
      check("model_s0", int'(seconds0), m_tot % 10);
      check("model_done", int'(done), int'(m_done));
      check("model_expired", int'(expired), int'(m_tot == 0));
      check("done_not_consecutive", int'(done && prev_done), 0);
      prev_done = done;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int m, input int s1, input int s0,
                            input int exp_x, input int exp_d);
    check({name, "_m0"}, int'(minutes0), m);
    check({name, "_s1"}, int'(seconds1), s1);
    check({name, "_s0"}, int'(seconds0), s0);
    check({name, "_expired"}, int'(expired), exp_x);
    check({name, "_done"}, int'(done), exp_d);
  endtask

  task automatic do_load(input int m, input int s1, input int s0, input logic cnt);
    minutes0_in = 4'(m);
    seconds1_in = 4'(s1);
    seconds0_in = 4'(s0);
    load  = 1'b1;
    count = cnt;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; count = 1'b0; load = 1'b0;
    minutes0_in = '0; seconds1_in = '0; seconds0_in = '0;

    // 1: reset, then counting from 0:00 does nothing
    step(2);
    expect_out("reset", 0, 0, 0, 1, 0);
    reset = 1'b0; count = 1'b1;
    step(20);
    expect_out("idle_count", 0, 0, 0, 1, 0);

    // 2: 2:00 with double borrow
    do_load(2, 0, 0, 1'b1);
    expect_out("load_200", 2, 0, 0, 0, 0);
    step(3);
    expect_out("pre_tick", 2, 0, 0, 0, 0);
    step(1);
    expect_out("borrow_159", 1, 5, 9, 0, 0);
    step(4);
    expect_out("tick_158", 1, 5, 8, 0, 0);

    // 3: expiry from 0:02
    do_load(0, 0, 2, 1'b1);
    step(4);
    expect_out("exp_001", 0, 0, 1, 0, 0);
    step(4);
    expect_out("exp_done", 0, 0, 0, 1, 1);
    step(1);
    expect_out("done_clear", 0, 0, 0, 1, 0);
    step(40);
    expect_out("exp_hold", 0, 0, 0, 1, 0);

    // 4: pause keeps the partial second
    do_load(0, 0, 5, 1'b1);
    step(6);
    expect_out("run6", 0, 0, 4, 0, 0);
    count = 1'b0;
    step(20);
    expect_out("paused", 0, 0, 4, 0, 0);
    count = 1'b1;
    step(1);
    expect_out("resume1", 0, 0, 4, 0, 0);
    step(1);
    expect_out("resume2", 0, 0, 3, 0, 0);

    // 5: clamping and loading 0:00
    do_load(12, 7, 11, 1'b0);
    expect_out("clamp", 9, 5, 9, 0, 0);
    do_load(0, 0, 0, 1'b0);
    expect_out("load_zero", 0, 0, 0, 1, 0);
    step(1);
    expect_out("load_zero_nodone", 0, 0, 0, 1, 0);

    // 6: load wins over tick, then reset mid-second
    do_load(0, 1, 0, 1'b1);
    step(3);
    expect_out("pre_load_tick", 0, 1, 0, 0, 0);
    do_load(3, 3, 0, 1'b1);
    expect_out("load_wins", 3, 3, 0, 0, 0);
    step(2);
    expect_out("after_load", 3, 3, 0, 0, 0);
    reset = 1'b1;
    step(1);
    expect_out("mid_reset", 0, 0, 0, 1, 0);
    reset = 1'b0;
    step(3);
    expect_out("post_reset", 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
